// File: rtl/branch_redirect_ctrl_if.sv
// Handshake bundle between fetch, execute and the branch redirect controller.
// The master side is the controller; the slave side is the surrounding pipeline.
interface branch_redirect_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic             pred_valid_i;
    logic             pred_taken_i;
    logic [31:0]      pred_target_i;
    logic [31:0]      pred_fallthru_i;
    logic             pred_ready_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             redirect_ready_i;
    logic             resolve_valid_i;
    logic             resolve_taken_i;
    logic [31:0]      resolve_target_i;
    logic             flush_o;
    logic [OW-1:0]    outstanding_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    modport master (
        input  pred_valid_i, pred_taken_i, pred_target_i, pred_fallthru_i,
        input  redirect_ready_i,
        input  resolve_valid_i, resolve_taken_i, resolve_target_i,
        output pred_ready_o, redirect_valid_o, redirect_pc_o,
        output flush_o, outstanding_o, branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        output pred_valid_i, pred_taken_i, pred_target_i, pred_fallthru_i,
        output redirect_ready_i,
        output resolve_valid_i, resolve_taken_i, resolve_target_i,
        input  pred_ready_o, redirect_valid_o, redirect_pc_o,
        input  flush_o, outstanding_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Tracks outstanding predicted branches, issues fetch redirects for taken
// predictions and for mispredict recovery, and keeps resolve statistics.
module branch_redirect_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    branch_redirect_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] exp_pc;
        logic [31:0] fallthru;
    } entry_t;

    state_t           state_q;
    state_t           state_d;
    entry_t           q_mem [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [OW-1:0]    count_q;
    logic             rdr_valid_q;
    logic [31:0]      rdr_pc_q;
    logic             flush_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;

    logic   pred_ready;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   mispredict;
    logic   rdr_hs;
    entry_t head_e;
    entry_t push_e;

    assign full   = (count_q == OW'(DEPTH));
    assign empty  = (count_q == '0);
    assign head_e = q_mem[head_q];
    assign rdr_hs = rdr_valid_q & bus.redirect_ready_i;
    assign push   = bus.pred_valid_i & pred_ready;
    assign pop    = bus.resolve_valid_i & (state_q == RUN) & ~empty;

    assign mispredict = pop &
        ((bus.resolve_taken_i != head_e.taken) |
         (bus.resolve_taken_i & head_e.taken &
          (bus.resolve_target_i != head_e.exp_pc)));

    assign push_e = '{
        taken:    bus.pred_taken_i,
        exp_pc:   bus.pred_taken_i ? bus.pred_target_i
                                   : bus.pred_fallthru_i,
        fallthru: bus.pred_fallthru_i
    };

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next state: a mispredict enters recovery, its redirect handshake leaves.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (mispredict) state_d = RECOVER;
            RECOVER: if (rdr_hs)     state_d = RUN;
        endcase
    end

    // Accept new predictions only in RUN with room and no redirect pending.
    always_comb begin
        pred_ready = 1'b0;
        if ((state_q == RUN) && !full && !rdr_valid_q) pred_ready = 1'b1;
    end

    // Branch queue; a mispredict empties it and drops a same-cycle push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
        end else if (mispredict) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                q_mem[tail_q] <= push_e;
                tail_q        <= tail_q + AW'(1);
            end
            if (pop) head_q <= head_q + AW'(1);
            if (push && !pop)      count_q <= count_q + OW'(1);
            else if (pop && !push) count_q <= count_q - OW'(1);
        end
    end

    // Redirect request; recovery target wins over a pending prediction target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdr_valid_q <= 1'b0;
            rdr_pc_q    <= '0;
        end else if (mispredict) begin
            rdr_valid_q <= 1'b1;
            rdr_pc_q    <= bus.resolve_taken_i ? bus.resolve_target_i
                                               : head_e.fallthru;
        end else if (rdr_hs) begin
            rdr_valid_q <= 1'b0;
            rdr_pc_q    <= '0;
        end else if (push && bus.pred_taken_i) begin
            rdr_valid_q <= 1'b1;
            rdr_pc_q    <= bus.pred_target_i;
        end
    end

    // One-cycle flush pulse following a mispredict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) flush_q <= 1'b0;
        else       flush_q <= mispredict;
    end

    // Saturating resolve statistics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (pop && (br_cnt_q != '1))
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispredict && (mp_cnt_q != '1))
                mp_cnt_q <= mp_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pred_ready_o     = pred_ready;
    assign bus.redirect_valid_o = rdr_valid_q;
    assign bus.redirect_pc_o    = rdr_pc_q;
    assign bus.flush_o          = flush_q;
    assign bus.outstanding_o    = count_q;
    assign bus.branch_cnt_o     = br_cnt_q;
    assign bus.mispredict_cnt_o = mp_cnt_q;
endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, outstanding-branch queue depth; power of two, minimum 2, the only legal values.
REQ-002 Parameter CNT_W, default 16, statistics counter width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 pred_valid_i  in  1  a fetched control-flow instruction with its static prediction is offered.
REQ-006 pred_taken_i  in  1  static predictor taken decision.
REQ-007 pred_target_i  in  32  static predictor target PC.
REQ-008 pred_fallthru_i  in  32  sequential PC after the instruction (PC+2 or PC+4).
REQ-009 pred_ready_o  out  1  prediction accepted when pred_valid_i & pred_ready_o.
REQ-010 redirect_valid_o  out  1  fetch redirect request.
REQ-011 redirect_pc_o  out  32  redirect destination.
REQ-012 redirect_ready_i  in  1  fetch accepts redirect when redirect_valid_o & redirect_ready_i.
REQ-013 resolve_valid_i  in  1  execute stage resolves the oldest outstanding branch, in program order.
REQ-014 resolve_taken_i  in  1  actual direction.
REQ-015 resolve_target_i  in  32  actual taken target.
REQ-016 flush_o  out  1  one-cycle pulse: discard younger instructions.
REQ-017 outstanding_o  out  $clog2(DEPTH)+1  current queue occupancy.
REQ-018 branch_cnt_o  out  CNT_W  resolved-branch count.
REQ-019 mispredict_cnt_o  out  CNT_W  mispredict count.

Function
REQ-020 States: RUN and RECOVER; reset enters RUN.
REQ-021 pred_ready_o = (state==RUN) & (queue not full) & ~redirect_valid_o; no same-cycle pop bypass when full.
REQ-022 Accept pushes {pred_taken_i, exp_pc = pred_taken_i ? pred_target_i : pred_fallthru_i, pred_fallthru_i} at queue tail.
REQ-023 Accepted taken prediction in cycle N: redirect_valid_o=1, redirect_pc_o=pred_target_i from cycle N+1; not-taken: no redirect.
REQ-024 redirect_valid_o and redirect_pc_o are held stable until the handshake cycle; cleared the cycle after it.
REQ-025 resolve_valid_i with empty queue, or in RECOVER: ignored; no state, queue or counter change.
REQ-026 resolve_valid_i in RUN with non-empty queue pops head; mispredict = (resolve_taken_i != head.taken) | (resolve_taken_i & head.taken & resolve_target_i != head.exp_pc).
REQ-027 Correct resolve: pop only; simultaneous accept and pop leave outstanding_o unchanged.
REQ-028 Mispredict in cycle N, at edge: queue cleared to empty, redirect_valid_o=1, redirect_pc_o = resolve_taken_i ? resolve_target_i : head.fallthru, state=RECOVER; flush_o=1 during cycle N+1 only.
REQ-029 Mispredict overrides any pending prediction redirect; old target discarded, no handshake on it.
REQ-030 A prediction accepted in the same cycle as a mispredict is dropped (not pushed, no redirect).
REQ-031 RECOVER -> RUN on the recovery redirect handshake; pred_ready_o=0 throughout RECOVER.
REQ-032 branch_cnt_o +1 per popped resolve; mispredict_cnt_o +1 per mispredict; both saturate at all-ones.
REQ-033 Queue pointers wrap modulo DEPTH; occupancy 0..DEPTH exactly.

Reset
REQ-034 While rst_i high: state RUN, queue empty, outstanding_o=0, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, both counters 0, pred_ready_o=1.
REQ-035 Reset asserted mid-operation (pending redirect, RECOVER, full queue) discards all state immediately, without waiting for a clock edge.

Verification
REQ-036 Taken push target 0x100, redirect_ready_i=1 -> redirect_valid_o=1, redirect_pc_o=0x100 next cycle, one cycle only; outstanding_o=1.
REQ-037 Push 4 not-taken (DEPTH=4) -> pred_ready_o=0, outstanding_o=4; resolve 4 not-taken -> outstanding_o=0, branch_cnt_o=4, mispredict_cnt_o=0, no flush.
REQ-038 Push not-taken fallthru 0x204, resolve taken target 0x300 -> flush_o pulse, redirect_pc_o=0x300, outstanding_o=0, mispredict_cnt_o=1; redirect_ready_i held 0 for 3 cycles keeps RECOVER and pred_ready_o=0.
REQ-039 Push taken target 0x80 fallthru 0x44, resolve not-taken -> redirect_pc_o=0x44; taken resolve with target 0x84 -> redirect_pc_o=0x84.
REQ-040 resolve_valid_i on empty queue, and mispredict coinciding with new push -> counters unchanged / push dropped, outstanding_o=0.
REQ-041 Assert rst_i between clock edges during RECOVER with redirect pending -> all outputs at REQ-034 values immediately.
